control32_multicycle: RTL and testbench
=======================================

Name: control32_multicycle

Overview:
- Multi-cycle control sequencer for the 32-bit MIPS core.
- Drives the execute unit's control inputs (ALUOp, Sftmd, ALUSrc, I_format, Jr) and consumes its Zero flag.
- Sequences fetch/decode/execute/memory/writeback and issues PC, register-file and memory/IO strobes with req/ack handshakes toward instruction fetch and memory/IO.

Parameters:
- OPC_W, 6, opcode and function field width.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Instruction  in  32  fetched word; valid while Ifetch_ack=1
- Ifetch_req  out  1  instruction fetch request
- Ifetch_ack  in  1  fetch complete
- Mem_req  out  1  data memory/IO request
- Mem_ack  in  1  data access complete
- Zero  in  1  execute-unit zero flag; sampled only in EXEC
- ALUOp  out  2  {R_format|I_format, Branch|nBranch}
- Sftmd  out  1  shift instruction
- ALUSrc  out  1  second operand is immediate
- I_format  out  1  opcode[5:3]==3'b001
- Jr  out  1  R-type with funct 6'b001000
- RegDST  out  1  destination is rd
- Jal  out  1  write PC+4 to $31
- RegWrite  out  1  register-file write strobe
- MemRead  out  1  load access
- MemWrite  out  1  store access
- MemorIOtoReg  out  1  writeback source is memory/IO
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 jr
- PCWrite  out  1  one-cycle retire pulse; PC loads per PCSrc
- Halt  out  1  (ILLEGAL_TRAP_EN only) core stopped

Behaviour:
- Reset (async, rst_n=0):
  - State=FETCH; opcode/funct registers=0; PCSrc=00.
  - Ifetch_req, Mem_req, RegWrite, MemRead, MemWrite, PCWrite, Halt=0 immediately.
- States and transitions:
  - FETCH: Ifetch_req=1. On Ifetch_ack, latch Instruction[31:26] and [5:0]; go to DECODE. Otherwise hold.
  - DECODE: 1 cycle. Illegal opcode -> see Optional Feature. Otherwise go to EXEC.
  - EXEC: 1 cycle. Register PCSrc:
    - 01 if (beq&Zero)|(bne&!Zero), else 00 for branches.
    - 10 for j/jal; 11 for jr.
    - Next state: lw/sw -> MEM; R-type (not jr)/I_format/jal -> WB; beq/bne/j/jr -> FETCH with PCWrite=1.
  - MEM: Mem_req=1; MemRead=lw, MemWrite=sw, held stable until Mem_ack. On ack: lw -> WB; sw -> FETCH with PCWrite=1.
  - WB: RegWrite=1 for one cycle; MemorIOtoReg=lw. Go to FETCH with PCWrite=1.
- Decoded outputs:
  - Combinational from latched fields, valid DECODE..WB.
  - Sftmd = R_format & funct[5:3]==0.
  - ALUSrc = I_format|lw|sw.
  - RegDST = R_format.
- Latency with zero-wait acks: R/I=4, lw=5, sw=4, beq/bne/j/jr=3, jal=4 cycles.
- Exactly one PCWrite pulse per retired instruction.
- PCSrc holds its value until the next EXEC.
- An ack arriving while the matching req=0 is ignored.
- Reset mid-MEM drops Mem_req and MemWrite in the same cycle; no write strobe is reissued.
- Legal opcodes: 000000 (any funct), 000010, 000011, 000100, 000101, 001xxx, 100011, 101011.

Optional Feature:
- ILLEGAL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to HALT.
  - HALT asserts Halt=1 and all strobes 0; it exits only via reset.
- ILLEGAL_TRAP_EN undefined:
  - An illegal opcode is a NOP: DECODE -> FETCH with PCSrc=00 and PCWrite=1.
  - The Halt port is absent.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW)
  - FUNCT_JR
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - PCSrc encodings
- Sub-module: control32_decode, purely combinational opcode/funct -> decoded controls plus illegal flag. The sequencer instantiates it.

Test Plan:
- add $3,$1,$2 (0x00221820), acks immediate -> ALUOp=2'b10, RegDST=1, RegWrite on cycle 4, PCWrite on cycle 4, PCSrc=00.
- lw (0x8C220004), Mem_ack delayed 3 cycles -> MemRead/Mem_req held 4 cycles; RegWrite with MemorIOtoReg=1 on the following cycle; total 8 cycles.
- beq (0x10220003), Zero=1 then Zero=0 -> PCSrc=01 then 00; ALUOp=2'b01; PCWrite on cycle 3; no RegWrite.
- jr $31 (0x03E00008) -> Jr=1, PCSrc=11, no WB cycle; jal (0x0C000010) -> Jal=1, PCSrc=10, RegWrite in WB.
- rst_n low during MEM of sw -> Mem_req and MemWrite fall without a clock edge; after release, Ifetch_req=1 in FETCH.
- Opcode 0x3F -> ILLEGAL_TRAP_EN: Halt=1, all strobes 0 indefinitely; without the macro: PCWrite pulse, then Ifetch_req=1.

Source files
------------

// File: rtl/control32_multicycle_pkg.sv
// control32_multicycle_pkg
// Shared definitions for the multi-cycle MIPS control sequencer:
// opcode/funct constants, PCSrc encodings and the sequencer state enum.
`timescale 1ns/1ps
package control32_multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // All I-format ALU opcodes share this top-three-bit prefix.
  localparam logic [2:0] IFMT_PREFIX = 3'b001;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/control32_decode.sv
// control32_decode
// Purely combinational decode of the latched opcode/funct fields into the
// execute-unit controls, instruction-class flags and an illegal-opcode flag.
// Ports:
//   opcode_i, funct_i : latched instruction fields
//   aluOp_o           : {R_format|I_format, beq|bne}
//   sftmd_o, aluSrc_o, iFormat_o, jr_o, regDst_o, jal_o : execute/writeback controls
//   isLw_o, isSw_o, isBeq_o, isBne_o, isJ_o : instruction class for sequencing
//   illegal_o         : opcode is outside the supported set
`timescale 1ns/1ps
module control32_decode
  import control32_multicycle_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [OPC_W-1:0] funct_i,
  output logic [1:0]       aluOp_o,
  output logic             sftmd_o,
  output logic             aluSrc_o,
  output logic             iFormat_o,
  output logic             jr_o,
  output logic             regDst_o,
  output logic             jal_o,
  output logic             isLw_o,
  output logic             isSw_o,
  output logic             isBeq_o,
  output logic             isBne_o,
  output logic             isJ_o,
  output logic             illegal_o
);

  logic rFormat;

  assign rFormat   = (opcode_i == OP_RTYPE);
  assign iFormat_o = (opcode_i[OPC_W-1:OPC_W-3] == IFMT_PREFIX);
  assign isLw_o    = (opcode_i == OP_LW);
  assign isSw_o    = (opcode_i == OP_SW);
  assign isBeq_o   = (opcode_i == OP_BEQ);
  assign isBne_o   = (opcode_i == OP_BNE);
  assign isJ_o     = (opcode_i == OP_J);
  assign jal_o     = (opcode_i == OP_JAL);

  assign jr_o      = rFormat & (funct_i == FUNCT_JR);
  // Shift functs (sll/srl/sra and variable forms) all have funct[5:3]==000.
  assign sftmd_o   = rFormat & (funct_i[OPC_W-1:OPC_W-3] == 3'b000);
  assign aluSrc_o  = iFormat_o | isLw_o | isSw_o;
  assign regDst_o  = rFormat;
  assign aluOp_o   = {rFormat | iFormat_o, isBeq_o | isBne_o};

  assign illegal_o = ~(rFormat | iFormat_o | isLw_o | isSw_o |
                       isBeq_o | isBne_o | isJ_o | jal_o);

endmodule

// File: rtl/control32_multicycle.sv
// control32_multicycle
// Multi-cycle control sequencer for the 32-bit MIPS core. Walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction
// fetch and data memory/IO, and issues one PCWrite pulse per retired instruction.
// Configuration macro: ILLEGAL_TRAP_EN -- illegal opcodes halt the core and the
// Halt port exists; otherwise illegal opcodes retire as NOPs.
// Ports:
//   clock, rst_n               : clock, asynchronous active-low reset
//   Instruction, Ifetch_req/ack: instruction fetch handshake
//   Mem_req/ack                : data memory/IO handshake
//   Zero                       : execute-unit zero flag (used in EXEC only)
//   ALUOp, Sftmd, ALUSrc, I_format, Jr : execute-unit controls
//   RegDST, Jal, RegWrite, MemRead, MemWrite, MemorIOtoReg : datapath strobes
//   PCSrc, PCWrite             : next-PC select and retire pulse
//   Halt                       : core stopped (ILLEGAL_TRAP_EN only)
`timescale 1ns/1ps
module control32_multicycle
  import control32_multicycle_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  output logic        Ifetch_req,
  input  logic        Ifetch_ack,
  output logic        Mem_req,
  input  logic        Mem_ack,
  input  logic        Zero,
  output logic [1:0]  ALUOp,
  output logic        Sftmd,
  output logic        ALUSrc,
  output logic        I_format,
  output logic        Jr,
  output logic        RegDST,
  output logic        Jal,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemorIOtoReg,
  output logic [1:0]  PCSrc,
  output logic        PCWrite
`ifdef ILLEGAL_TRAP_EN
 ,output logic        Halt
`endif
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opcode_q, opcode_d;
  logic [OPC_W-1:0] funct_q, funct_d;
  logic [1:0]       pcSrc_q, pcSrc_d;

  logic isLw, isSw, isBeq, isBne, isJ, illegal;
  logic unusedInstrBits;

  assign unusedInstrBits = ^Instruction[31-OPC_W:OPC_W];

  control32_decode #(.OPC_W(OPC_W)) uDecode (
    .opcode_i  (opcode_q),
    .funct_i   (funct_q),
    .aluOp_o   (ALUOp),
    .sftmd_o   (Sftmd),
    .aluSrc_o  (ALUSrc),
    .iFormat_o (I_format),
    .jr_o      (Jr),
    .regDst_o  (RegDST),
    .jal_o     (Jal),
    .isLw_o    (isLw),
    .isSw_o    (isSw),
    .isBeq_o   (isBeq),
    .isBne_o   (isBne),
    .isJ_o     (isJ),
    .illegal_o (illegal)
  );

  // The PC mux sees the value being registered this cycle, so the PCWrite
  // pulse issued from EXEC (or an illegal-opcode NOP) already uses the new select.
  assign PCSrc = pcSrc_d;

  // State, latched instruction fields and the held PC select.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
      pcSrc_q  <= PCSRC_SEQ;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      pcSrc_q  <= pcSrc_d;
    end
  end

  // Next-state and strobe generation. Strobes are decoded from the state
  // register so an asynchronous reset removes them without a clock edge.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    funct_d      = funct_q;
    pcSrc_d      = pcSrc_q;
    Ifetch_req   = 1'b0;
    Mem_req      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    MemorIOtoReg = 1'b0;
    PCWrite      = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    Halt         = 1'b0;
`endif

    case (state_q)
      FETCH: begin
        // FETCH is also the reset state; keep the request low while held in reset.
        Ifetch_req = rst_n;
        if (Ifetch_ack) begin
          opcode_d = Instruction[31:32-OPC_W];
          funct_d  = Instruction[OPC_W-1:0];
          state_d  = DECODE;
        end
      end

      DECODE: begin
        if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = HALT;
`else
          state_d = FETCH;
          pcSrc_d = PCSRC_SEQ;
          PCWrite = 1'b1;
`endif
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        pcSrc_d = PCSRC_SEQ;
        if ((isBeq & Zero) | (isBne & ~Zero)) pcSrc_d = PCSRC_BRANCH;
        else if (isJ | Jal)                   pcSrc_d = PCSRC_JUMP;
        else if (Jr)                          pcSrc_d = PCSRC_JR;

        if (isLw | isSw) begin
          state_d = MEM;
        end else if (isBeq | isBne | isJ | Jr) begin
          state_d = FETCH;
          PCWrite = 1'b1;
        end else begin
          state_d = WB;
        end
      end

      MEM: begin
        Mem_req  = 1'b1;
        MemRead  = isLw;
        MemWrite = isSw;
        if (Mem_ack) begin
          if (isLw) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
            PCWrite = 1'b1;
          end
        end
      end

      WB: begin
        RegWrite     = 1'b1;
        MemorIOtoReg = isLw;
        PCWrite      = 1'b1;
        state_d      = FETCH;
      end

`ifdef ILLEGAL_TRAP_EN
      HALT: begin
        Halt = 1'b1;
      end
`endif

      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_control32_multicycle.sv
// tb_control32_multicycle
// Directed bench for control32_multicycle: runs single instructions through
// the sequencer with hand-computed latencies, strobes and PC selects.
`timescale 1ns/1ps
module tb_control32_multicycle;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instruction = '0;
  logic        Ifetch_req, Ifetch_ack = 1'b0;
  logic        Mem_req, Mem_ack = 1'b0;
  logic        Zero = 1'b0;
  logic [1:0]  ALUOp, PCSrc;
  logic        Sftmd, ALUSrc, I_format, Jr, RegDST, Jal;
  logic        RegWrite, MemRead, MemWrite, MemorIOtoReg, PCWrite;
`ifdef ILLEGAL_TRAP_EN
  logic        Halt;
`endif

  int checks   = 0;
  int failures = 0;

  // Per-instruction observations gathered by applyStimulus.
  int         latency, regWriteCnt, regWriteCyc, memReqCnt, memReadCnt, memWriteCnt, pcWriteCnt;
  logic       m2rAtWrite, sawPcWrite;
  logic [1:0] pcSrcAtWrite, pcSrcFirst, decAluOp;
  logic       decRegDst, decJr, decJal, decAluSrc, decSftmd, decIFmt;

  control32_multicycle dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .Instruction  (Instruction),
    .Ifetch_req   (Ifetch_req),
    .Ifetch_ack   (Ifetch_ack),
    .Mem_req      (Mem_req),
    .Mem_ack      (Mem_ack),
    .Zero         (Zero),
    .ALUOp        (ALUOp),
    .Sftmd        (Sftmd),
    .ALUSrc       (ALUSrc),
    .I_format     (I_format),
    .Jr           (Jr),
    .RegDST       (RegDST),
    .Jal          (Jal),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemorIOtoReg (MemorIOtoReg),
    .PCSrc        (PCSrc),
    .PCWrite      (PCWrite)
`ifdef ILLEGAL_TRAP_EN
   ,.Halt         (Halt)
`endif
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Runs one instruction starting in FETCH (called 1 ns after a rising edge).
  // Acks fetch immediately, acks memory after memWait extra cycles, and
  // records strobes until the PCWrite retire pulse or a 40-cycle bound.
  task automatic applyStimulus(input logic [31:0] instr, input int memWait, input logic zeroIn);
    int memSeen = 0;
    int cyc = 0;
    latency = 0; regWriteCnt = 0; regWriteCyc = 0; memReqCnt = 0;
    memReadCnt = 0; memWriteCnt = 0; pcWriteCnt = 0;
    m2rAtWrite = 1'b0; sawPcWrite = 1'b0; pcSrcAtWrite = 2'b00; pcSrcFirst = 2'b00;
    Instruction = instr;
    Zero = zeroIn;
    while (!sawPcWrite && cyc < 40) begin
      cyc++;
      Ifetch_ack = Ifetch_req;
      if (Mem_req) memSeen++;
      Mem_ack = Mem_req && (memSeen == memWait + 1);
      #1;
      if (cyc == 1) pcSrcFirst = PCSrc;
      if (cyc == 2) begin
        decAluOp = ALUOp; decRegDst = RegDST; decJr = Jr; decJal = Jal;
        decAluSrc = ALUSrc; decSftmd = Sftmd; decIFmt = I_format;
      end
      if (Mem_req)  memReqCnt++;
      if (MemRead)  memReadCnt++;
      if (MemWrite) memWriteCnt++;
      if (RegWrite) begin regWriteCnt++; regWriteCyc = cyc; m2rAtWrite = MemorIOtoReg; end
      if (PCWrite) begin pcWriteCnt++; pcSrcAtWrite = PCSrc; latency = cyc; sawPcWrite = 1'b1; end
      @(posedge clock); #1;
    end
    Ifetch_ack = 1'b0;
    Mem_ack = 1'b0;
    checkOutput("retired", {31'b0, sawPcWrite}, 32'd1);
  endtask

  initial begin
    int cyc;
    int haltCnt;
    int strobeCnt;

    // Reset state while rst_n is held low.
    #3;
    checkOutput("rst_ifetch_req", {31'b0, Ifetch_req}, 32'd0);
    checkOutput("rst_mem_req",    {31'b0, Mem_req},    32'd0);
    checkOutput("rst_regwrite",   {31'b0, RegWrite},   32'd0);
    checkOutput("rst_memwrite",   {31'b0, MemWrite},   32'd0);
    checkOutput("rst_pcwrite",    {31'b0, PCWrite},    32'd0);
    checkOutput("rst_pcsrc",      {30'b0, PCSrc},      32'd0);
    #9 rst_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("fetch_after_rst", {31'b0, Ifetch_req}, 32'd1);

    // add $3,$1,$2
    applyStimulus(32'h00221820, 0, 1'b0);
    checkOutput("add_latency",  latency,            32'd4);
    checkOutput("add_rw_cycle", regWriteCyc,        32'd4);
    checkOutput("add_aluop",    {30'b0, decAluOp},  32'd2);
    checkOutput("add_regdst",   {31'b0, decRegDst}, 32'd1);
    checkOutput("add_alusrc",   {31'b0, decAluSrc}, 32'd0);
    checkOutput("add_sftmd",    {31'b0, decSftmd},  32'd0);
    checkOutput("add_pcsrc",    {30'b0, pcSrcAtWrite}, 32'd0);

    // sll $1,$2,4
    applyStimulus(32'h00020900, 0, 1'b0);
    checkOutput("sll_sftmd",   {31'b0, decSftmd}, 32'd1);
    checkOutput("sll_latency", latency,           32'd4);

    // addi $1,$2,5
    applyStimulus(32'h20410005, 0, 1'b0);
    checkOutput("addi_ifmt",    {31'b0, decIFmt},   32'd1);
    checkOutput("addi_aluop",   {30'b0, decAluOp},  32'd2);
    checkOutput("addi_alusrc",  {31'b0, decAluSrc}, 32'd1);
    checkOutput("addi_regdst",  {31'b0, decRegDst}, 32'd0);
    checkOutput("addi_latency", latency,            32'd4);

    // lw with Mem_ack three cycles late
    applyStimulus(32'h8C220004, 3, 1'b0);
    checkOutput("lw_memreq_cycles",  memReqCnt,   32'd4);
    checkOutput("lw_memread_cycles", memReadCnt,  32'd4);
    checkOutput("lw_memwrite",       memWriteCnt, 32'd0);
    checkOutput("lw_rw_cycle",       regWriteCyc, 32'd8);
    checkOutput("lw_m2r",            {31'b0, m2rAtWrite}, 32'd1);
    checkOutput("lw_latency",        latency,     32'd8);
    checkOutput("lw_aluop",          {30'b0, decAluOp}, 32'd0);

    // sw with immediate ack
    applyStimulus(32'hAC220004, 0, 1'b0);
    checkOutput("sw_latency",   latency,     32'd4);
    checkOutput("sw_memwrite",  memWriteCnt, 32'd1);
    checkOutput("sw_memread",   memReadCnt,  32'd0);
    checkOutput("sw_regwrites", regWriteCnt, 32'd0);

    // beq taken then not taken
    applyStimulus(32'h10220003, 0, 1'b1);
    checkOutput("beq_t_pcsrc",    {30'b0, pcSrcAtWrite}, 32'd1);
    checkOutput("beq_aluop",      {30'b0, decAluOp},     32'd1);
    checkOutput("beq_latency",    latency,               32'd3);
    checkOutput("beq_regwrites",  regWriteCnt,           32'd0);
    checkOutput("beq_pcwrites",   pcWriteCnt,            32'd1);
    applyStimulus(32'h10220003, 0, 1'b0);
    checkOutput("beq_pcsrc_held", {30'b0, pcSrcFirst},   32'd1);
    checkOutput("beq_nt_pcsrc",   {30'b0, pcSrcAtWrite}, 32'd0);

    // bne with Zero=0 takes the branch
    applyStimulus(32'h14220003, 0, 1'b0);
    checkOutput("bne_pcsrc", {30'b0, pcSrcAtWrite}, 32'd1);

    // jr $31
    applyStimulus(32'h03E00008, 0, 1'b0);
    checkOutput("jr_flag",      {31'b0, decJr},        32'd1);
    checkOutput("jr_pcsrc",     {30'b0, pcSrcAtWrite}, 32'd3);
    checkOutput("jr_latency",   latency,               32'd3);
    checkOutput("jr_regwrites", regWriteCnt,           32'd0);

    // jal 0x10
    applyStimulus(32'h0C000010, 0, 1'b0);
    checkOutput("jal_pcsrc_held", {30'b0, pcSrcFirst},   32'd3);
    checkOutput("jal_flag",       {31'b0, decJal},       32'd1);
    checkOutput("jal_pcsrc",      {30'b0, pcSrcAtWrite}, 32'd2);
    checkOutput("jal_latency",    latency,               32'd4);
    checkOutput("jal_regwrites",  regWriteCnt,           32'd1);

    // j 0x10 leaves PCSrc=10 ahead of the illegal opcode
    applyStimulus(32'h08000010, 0, 1'b0);
    checkOutput("j_pcsrc", {30'b0, pcSrcAtWrite}, 32'd2);

    // Illegal opcode 0x3F
    Instruction = 32'hFC000000;
    Ifetch_ack = 1'b1;
    @(posedge clock); #1;
    Ifetch_ack = 1'b0;
    #1;
`ifdef ILLEGAL_TRAP_EN
    checkOutput("ill_no_pcwrite", {31'b0, PCWrite}, 32'd0);
    Ifetch_ack = 1'b1;
    haltCnt = 0;
    strobeCnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (Halt) haltCnt++;
      if (Ifetch_req | Mem_req | RegWrite | PCWrite | MemRead | MemWrite) strobeCnt++;
    end
    Ifetch_ack = 1'b0;
    checkOutput("ill_halt_cycles", haltCnt,   32'd5);
    checkOutput("ill_strobes",     strobeCnt, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("ill_halt_rst", {31'b0, Halt}, 32'd0);
`else
    checkOutput("ill_pcwrite", {31'b0, PCWrite}, 32'd1);
    checkOutput("ill_pcsrc",   {30'b0, PCSrc},   32'd0);
    @(posedge clock); #1;
    checkOutput("ill_fetch",     {31'b0, Ifetch_req}, 32'd1);
    checkOutput("ill_pcsrc_hold", {30'b0, PCSrc},     32'd0);
    rst_n = 1'b0;
`endif
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock); #1;

    // Reset asserted while sw waits in MEM
    Instruction = 32'hAC220004;
    Mem_ack = 1'b0;
    Ifetch_ack = 1'b1;
    cyc = 0;
    #1;
    while (!Mem_req && cyc < 10) begin
      @(posedge clock); #1;
      Ifetch_ack = 1'b0;
      cyc++;
      #1;
    end
    checkOutput("swrst_memwrite_before", {31'b0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("swrst_memreq",   {31'b0, Mem_req},    32'd0);
    checkOutput("swrst_memwrite", {31'b0, MemWrite},   32'd0);
    checkOutput("swrst_ifetch",   {31'b0, Ifetch_req}, 32'd0);
    @(negedge clock) rst_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("swrst_fetch_after", {31'b0, Ifetch_req}, 32'd1);
    checkOutput("swrst_no_rewrite",  {31'b0, MemWrite},   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
